// File: rtl/obstacle_row_scheduler.sv
// Per-frame obstacle row sequencer: loads random row speeds, ramps them on level-up and
// issues one valid/ready update request per row. OBSTACLE_SCHED_OVERRUN_CNT_EN adds overrun_cnt.
module obstacle_row_scheduler #(
  parameter int NUM_ROWS   = 6,
  parameter int MIN_SPEED  = 12,
  parameter int MAX_SPEED  = 24,
  parameter int SPEED_STEP = 2,
  parameter int TIME_W     = 32
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic [1:0]                  gameState,
  input  logic                        frame_start,
  input  logic                        level_up,
  input  logic [9:0]                  lfsr_in,
  output logic                        upd_valid,
  input  logic                        upd_ready,
  output logic [$clog2(NUM_ROWS)-1:0] upd_row,
  output logic                        upd_dir,
  output logic [7:0]                  upd_speed,
  output logic [TIME_W-1:0]           upd_time,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        overrun,
  output logic [3:0]                  level
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]                  overrun_cnt
`endif
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int RANGE = MAX_SPEED - MIN_SPEED + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ISSUE} state_t;

  state_t            state, next_state;
  logic [7:0]        speed      [NUM_ROWS];
  logic [7:0]        speed_next [NUM_ROWS];
  logic [ROW_W-1:0]  load_cnt;
  logic [ROW_W-1:0]  row_next;
  logic [TIME_W-1:0] time_cnt;
  logic [9:0]        load_val;
  logic [8:0]        ramp_sum;
  logic              pending;
  logic              play;
  logic              ramp;
  logic              accept;
  logic              last_hs;
  logic              drop;
  logic              load_entry;

  assign play    = (gameState == 2'b01);
  assign upd_dir = upd_row[0];

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Leaving play aborts from any state; the upd_* row register advances only on a handshake.
  always_comb begin
    next_state = state;
    row_next   = upd_row;
    accept     = 1'b0;
    ramp       = 1'b0;
    last_hs    = 1'b0;
    drop       = 1'b0;
    load_entry = 1'b0;
    if (!play) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          next_state = LOAD;
          load_entry = 1'b1;
        end
        LOAD: begin
          drop = frame_start;
          if (load_cnt == LAST_ROW) next_state = WAIT;
        end
        WAIT: begin
          ramp = pending | level_up;
          if (frame_start) begin
            accept     = 1'b1;
            row_next   = '0;
            next_state = ISSUE;
          end
        end
        ISSUE: begin
          drop = frame_start;
          if (upd_ready) begin
            if (upd_row == LAST_ROW) begin
              last_hs    = 1'b1;
              next_state = WAIT;
            end else begin
              row_next = upd_row + ROW_W'(1);
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Ramped speeds are visible combinationally so a same-cycle frame_start issues them.
  always_comb begin
    ramp_sum = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      speed_next[r] = speed[r];
      ramp_sum      = {1'b0, speed[r]} + 9'(SPEED_STEP);
      if (ramp) speed_next[r] = (ramp_sum > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : ramp_sum[7:0];
    end
  end

  assign load_val = ((lfsr_in ^ 10'(load_cnt)) % 10'(RANGE)) + 10'(MIN_SPEED);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid  <= 1'b0;
      upd_row    <= '0;
      upd_speed  <= '0;
      upd_time   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      level      <= '0;
      load_cnt   <= '0;
      time_cnt   <= '0;
      pending    <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) speed[r] <= 8'(MIN_SPEED);
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
      overrun_cnt <= '0;
`endif
    end else begin
      upd_valid  <= (next_state == ISSUE);
      busy       <= (next_state == LOAD) || (next_state == ISSUE);
      frame_done <= last_hs;
      upd_row    <= row_next;
      if (next_state == ISSUE) upd_speed <= speed_next[row_next];

      if (load_entry) begin
        load_cnt <= '0;
        time_cnt <= '0;
        level    <= '0;
        overrun  <= 1'b0;
        pending  <= 1'b0;
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
        overrun_cnt <= '0;
`endif
      end else begin
        if (play && state == LOAD) begin
          speed[load_cnt] <= load_val[7:0];
          load_cnt        <= load_cnt + ROW_W'(1);
        end
        if (ramp) begin
          for (int r = 0; r < NUM_ROWS; r++) speed[r] <= speed_next[r];
          if (level != 4'hF) level <= level + 4'd1;
          pending <= 1'b0;
        end else if (play && level_up && state != IDLE) begin
          pending <= 1'b1;
        end
        if (accept) begin
          upd_time <= time_cnt;
          time_cnt <= time_cnt + TIME_W'(1);
        end
        if (drop) begin
          overrun <= 1'b1;
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_obstacle_row_scheduler.sv
// Directed, table-driven bench for obstacle_row_scheduler (default parameters,
// lfsr_in = 0 on the first load, 10'h3FF on the reload after an abort).
module tb_obstacle_row_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic [1:0]  gameState;
  logic        frame_start;
  logic        level_up;
  logic [9:0]  lfsr_in;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_row;
  logic        upd_dir;
  logic [7:0]  upd_speed;
  logic [31:0] upd_time;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [3:0]  level;
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic fs, rdy, lu;
    logic exp_valid;
    int   exp_row, exp_speed, exp_time;
    logic exp_done, exp_busy, exp_over;
    int   exp_level;
  } vec_t;

  vec_t vecs[$];

  obstacle_row_scheduler dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .gameState  (gameState),
    .frame_start(frame_start),
    .level_up   (level_up),
    .lfsr_in    (lfsr_in),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_row    (upd_row),
    .upd_dir    (upd_dir),
    .upd_speed  (upd_speed),
    .upd_time   (upd_time),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .level      (level)
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic fs, rdy, lu, valid, input int row, spd, tm,
                              input logic done, bsy, over, input int lvl);
    vec_t v;
    v.fs = fs; v.rdy = rdy; v.lu = lu;
    v.exp_valid = valid; v.exp_row = row; v.exp_speed = spd; v.exp_time = tm;
    v.exp_done = done; v.exp_busy = bsy; v.exp_over = over; v.exp_level = lvl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    frame_start = v.fs;
    upd_ready   = v.rdy;
    level_up    = v.lu;
    tick();
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check_val($sformatf("v%0d valid", idx), int'(upd_valid), int'(v.exp_valid));
    check_val($sformatf("v%0d frame_done", idx), int'(frame_done), int'(v.exp_done));
    check_val($sformatf("v%0d busy", idx), int'(busy), int'(v.exp_busy));
    check_val($sformatf("v%0d overrun", idx), int'(overrun), int'(v.exp_over));
    check_val($sformatf("v%0d level", idx), int'(level), v.exp_level);
    if (v.exp_valid) begin
      check_val($sformatf("v%0d row", idx), int'(upd_row), v.exp_row);
      check_val($sformatf("v%0d dir", idx), int'(upd_dir), v.exp_row % 2);
      check_val($sformatf("v%0d speed", idx), int'(upd_speed), v.exp_speed);
      check_val($sformatf("v%0d time", idx), int'(upd_time), v.exp_time);
    end
  endtask

  initial begin
    int spd_a[6];
    int spd_b[6];
    spd_a = '{12, 13, 14, 15, 16, 17};
    spd_b = '{21, 20, 19, 18, 17, 16};

    // frame 1: free-flowing, time 0
    vecs.push_back(mk(1, 1, 0, 1, 0, 12, 0, 0, 1, 0, 0));
    for (int r = 1; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, spd_a[r], 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // frame 2: row 2 stalled three cycles, time 1
    vecs.push_back(mk(1, 0, 0, 1, 0, 12, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 13, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 2, 14, 1, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 1, 2, 14, 1, 0, 1, 0, 0));
    for (int r = 3; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, spd_a[r], 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // frame 3: dropped frame_start mid-frame, time 2
    vecs.push_back(mk(1, 1, 0, 1, 0, 12, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 13, 2, 0, 1, 1, 0));
    for (int r = 2; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, spd_a[r], 2, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    // frame 4: time only advanced once despite the drop
    vecs.push_back(mk(1, 0, 0, 1, 0, 12, 3, 0, 1, 1, 0));
    for (int r = 1; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, spd_a[r], 3, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    // frame 5: level_up with frame_start, then one during ISSUE left pending
    vecs.push_back(mk(1, 0, 1, 1, 0, 14, 4, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 1, 15, 4, 0, 1, 1, 1));
    for (int r = 2; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, spd_a[r] + 2, 4, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    for (int l = 3; l <= 7; l++) vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, l));
    // frame 6: every row saturated at MAX_SPEED
    vecs.push_back(mk(1, 0, 0, 1, 0, 24, 5, 0, 1, 1, 7));
    for (int r = 1; r < 6; r++) vecs.push_back(mk(0, 1, 0, 1, r, 24, 5, 0, 1, 1, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 7));

    reset_n = 1'b0; gameState = 2'b00; frame_start = 1'b0; level_up = 1'b0;
    lfsr_in = 10'h000; upd_ready = 1'b0;
    tick(); tick();
    check_val("reset valid", int'(upd_valid), 0);
    check_val("reset row", int'(upd_row), 0);
    check_val("reset dir", int'(upd_dir), 0);
    check_val("reset speed", int'(upd_speed), 0);
    check_val("reset time", int'(upd_time), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset frame_done", int'(frame_done), 0);
    check_val("reset overrun", int'(overrun), 0);
    check_val("reset level", int'(level), 0);
    reset_n = 1'b1;
    tick();
    check_val("idle busy", int'(busy), 0);

    $display("[TB] entering play, lfsr_in=0");
    gameState = 2'b01;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_val($sformatf("load%0d busy", c), int'(busy), 1);
    end
    tick();
    check_val("wait busy", int'(busy), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    frame_start = 1'b0; level_up = 1'b0; upd_ready = 1'b0;
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
    check_val("overrun_cnt", int'(overrun_cnt), 1);
`endif

    $display("[TB] level saturation");
    for (int k = 0; k < 10; k++) begin
      level_up = 1'b1;
      tick();
    end
    level_up = 1'b0;
    check_val("level saturate", int'(level), 15);

    $display("[TB] abort while row 3 stalled");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_val("abort row0 time", int'(upd_time), 6);
    upd_ready = 1'b1;
    tick(); tick(); tick();
    upd_ready = 1'b0;
    tick();
    check_val("stall valid", int'(upd_valid), 1);
    check_val("stall row", int'(upd_row), 3);
    gameState = 2'b00;
    tick();
    check_val("abort valid", int'(upd_valid), 0);
    check_val("abort busy", int'(busy), 0);
    check_val("abort frame_done", int'(frame_done), 0);
    tick();
    check_val("idle frame_done", int'(frame_done), 0);
    check_val("idle level hold", int'(level), 15);
    check_val("idle overrun hold", int'(overrun), 1);

    $display("[TB] reload, lfsr_in=3FF");
    gameState = 2'b01;
    lfsr_in = 10'h3FF;
    tick();
    check_val("reload busy", int'(busy), 1);
    check_val("reload level", int'(level), 0);
    check_val("reload overrun", int'(overrun), 0);
`ifdef OBSTACLE_SCHED_OVERRUN_CNT_EN
    check_val("reload overrun_cnt", int'(overrun_cnt), 0);
`endif
    for (int c = 0; c < 5; c++) tick();
    check_val("reload last load busy", int'(busy), 1);
    tick();
    check_val("reload wait busy", int'(busy), 0);
    frame_start = 1'b1;
    upd_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int r = 0; r < 6; r++) begin
      check_val($sformatf("reload r%0d valid", r), int'(upd_valid), 1);
      check_val($sformatf("reload r%0d row", r), int'(upd_row), r);
      check_val($sformatf("reload r%0d speed", r), int'(upd_speed), spd_b[r]);
      check_val($sformatf("reload r%0d time", r), int'(upd_time), 0);
      tick();
    end
    check_val("reload frame_done", int'(frame_done), 1);
    check_val("reload end valid", int'(upd_valid), 0);
    upd_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/obstacle_row_scheduler.md
# obstacle_row_scheduler

Sequencer that sits between the game-state logic and the shared obstacle position-update engine. Once per frame it walks every obstacle row and issues one update request per row over a valid/ready handshake. Each request carries the row index, direction, speed and frame time. It also owns the per-row speed configuration: randomized at game start, ramped on each level-up.

## Interface
Parameters:
- NUM_ROWS, 6, number of obstacle rows scheduled per frame (2..16)
- MIN_SPEED, 12, minimum row speed, unsigned 4.4 fixed point
- MAX_SPEED, 24, maximum row speed, 4.4 fixed point; must exceed MIN_SPEED
- SPEED_STEP, 2, speed increment applied to every row per level-up
- TIME_W, 32, width of frame-time counter

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- gameState  in  2  2'b01 = play; any other value = not playing
- frame_start  in  1  one-cycle pulse per video frame
- level_up  in  1  one-cycle pulse requesting a speed ramp
- lfsr_in  in  10  free-running pseudo-random value, sampled during LOAD
- upd_valid  out  1  update request valid
- upd_ready  in  1  update engine accepts the request
- upd_row  out  $clog2(NUM_ROWS)  row index of the request
- upd_dir  out  1  row direction, equal to upd_row[0]
- upd_speed  out  8  speed of the row
- upd_time  out  TIME_W  frame number latched at frame_start
- busy  out  1  high in LOAD or ISSUE
- frame_done  out  1  one-cycle pulse after the last row is accepted
- overrun  out  1  sticky: a frame_start was dropped
- level  out  4  current level, saturating at 15

## Operation
States:
- IDLE: entered on reset or whenever gameState != 2'b01.
- LOAD: entered from IDLE when gameState becomes 2'b01. Runs for exactly NUM_ROWS cycles, writing row r in cycle r with: speed[r] = MIN_SPEED + ((lfsr_in ^ r) % (MAX_SPEED - MIN_SPEED + 1)). Zero-extend r to 10 bits; compute in 10 bits. Also clears the time counter, level, overrun and the pending level-up flag. Then goes to WAIT.
- WAIT: on frame_start, latch the time counter into upd_time, increment the time counter (wraps modulo 2^TIME_W), set row = 0, go to ISSUE.
- ISSUE: drive upd_valid = 1, with upd_row/upd_dir/upd_speed/upd_time stable until handshake. A handshake is upd_valid & upd_ready in the same cycle. On handshake:
  - If row < NUM_ROWS-1, increment row and stay in ISSUE.
  - If row is the last row, go to WAIT and pulse frame_done.

Rules:
- frame_start in LOAD or ISSUE is dropped: overrun is set, the time counter does not increment, and nothing is queued.
- level_up in any play state sets a pending flag. The pending flag is applied only in WAIT, in a single cycle:
  - every speed[r] = min(speed[r] + SPEED_STEP, MAX_SPEED), computed with a 9-bit sum and no wrap;
  - level increments, saturating at 15;
  - the pending flag clears.
  Multiple level_up pulses while pending collapse into one.
- level_up and frame_start in the same WAIT cycle: the ramp is applied that cycle, and ISSUE starts next cycle using the ramped speeds.
- Leaving play (gameState != 2'b01) in any state: IDLE on the next edge. upd_valid drops even mid-handshake; the aborted frame produces no frame_done. Speeds, level, time and overrun hold their values until the next LOAD.
- frame_start is ignored in IDLE.

## Timing
- Reset values of outputs: upd_valid 0, upd_row 0, upd_dir 0, upd_speed 0, upd_time 0, busy 0, frame_done 0, overrun 0, level 0. Internally, all speed registers reset to MIN_SPEED.
- All outputs are registered.
- Entering play: busy rises one cycle after gameState becomes 2'b01. LOAD lasts NUM_ROWS cycles; WAIT is reached on cycle NUM_ROWS+1.
- frame_start in WAIT: upd_valid rises on the next edge (latency 1).
- With upd_ready held high, one row is accepted per cycle. A frame occupies NUM_ROWS cycles of upd_valid, and frame_done pulses on the cycle after the last handshake.
- upd_ready stalls hold all upd_* outputs constant. upd_valid never deasserts without a handshake, except on abort.
- A level ramp takes effect on speeds one cycle after it is applied in WAIT.

## Configuration
- OBSTACLE_SCHED_OVERRUN_CNT_EN defined: adds output port overrun_cnt (8 bits). It is an 8-bit count of dropped frame_start pulses, saturating at 255 and cleared in LOAD.
- Macro undefined: the port does not exist; only the sticky overrun flag reports drops.

## Test plan
- Reset, gameState=01, lfsr_in=10'h000, defaults -> after 6 LOAD cycles speeds = {12,13,14,15,16,17}. Equivalently (0^r)%13 + 12 for r = 0..5.
- frame_start with upd_ready=1 -> upd_valid for 6 consecutive cycles with upd_row 0..5, upd_dir alternating 0,1, upd_time=0. frame_done pulses once; the next frame carries upd_time=1.
- upd_ready low for 3 cycles on row 2 -> row 2 and its fields held for 4 cycles; total frame length 9 cycles.
- frame_start during ISSUE -> overrun=1, time counter unchanged, frame completes normally. With the macro defined, overrun_cnt=1.
- 7 level_up pulses, each applied in WAIT, starting from speed 17 -> speed saturates at 24 after 4 ramps, level=7. level_up and frame_start in the same cycle -> the ISSUE that starts next cycle carries the ramped speeds.
- gameState -> 2'b00 while row 3 is stalled -> upd_valid=0 the next cycle, no frame_done. Returning to 2'b01 -> LOAD runs again, level=0, overrun=0.
